// File: rtl/cpu_pkg.sv
// Shared CPU definitions: next-PC select encodings and architectural vectors.
package cpu_pkg;

    typedef enum logic [2:0] {
        PC_SEQ  = 3'b000,
        PC_BR   = 3'b001,
        PC_JUMP = 3'b010,
        PC_JR   = 3'b011,
        PC_INTR = 3'b100,
        PC_EXC  = 3'b101,
        PC_RSV6 = 3'b110,
        PC_RSV7 = 3'b111
    } pcsrc_e;

    localparam logic [31:0] RESET_VEC = 32'h8000_0000;
    localparam logic [31:0] ILLOP     = 32'h8000_0004;
    localparam logic [31:0] XADR      = 32'h8000_0008;
    localparam logic [31:0] NOP       = 32'h0000_0000;

    // Bit 31 is the supervisor bit; only the low 31 bits advance.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return {pc[31], pc[30:0] + 31'd4};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with hold, bubble and load controls.
module if_id_reg
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_hold,
    input  logic        i_bubble,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc_plus4,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc_plus4,
    output logic        o_valid
);

    logic [31:0] r_instr;
    logic [31:0] r_pc_plus4;
    logic        r_valid;

    // A bubble still records pc_plus4 so the supervisor bit stays coherent.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr    <= NOP;
            r_pc_plus4 <= RESET_VEC;
            r_valid    <= 1'b0;
        end else if (i_bubble) begin
            r_instr    <= NOP;
            r_pc_plus4 <= i_pc_plus4;
            r_valid    <= 1'b0;
        end else if (!i_hold) begin
            r_instr    <= i_instr;
            r_pc_plus4 <= i_pc_plus4;
            r_valid    <= 1'b1;
        end
    end

    assign o_instr    = r_instr;
    assign o_pc_plus4 = r_pc_plus4;
    assign o_valid    = r_valid;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, next-PC selection and IF/ID register.
module if_stage
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [2:0]  pcsrc,
    input  logic [25:0] jump_index,
    input  logic [31:0] jr_addr,
    input  logic        ex_br_taken,
    input  logic [31:0] ex_br_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc_plus4,
    output logic        ifid_valid,
    output logic        flush_idex
);

    logic [31:0] r_pc;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_redir_target;
    logic        w_redirect;
    logic [31:0] w_pc_next;
    logic        w_bubble;

    assign w_pc_plus4 = pc_inc(r_pc);

    always_comb begin
        w_redirect     = 1'b0;
        w_redir_target = w_pc_plus4;
        case (pcsrc_e'(pcsrc))
            PC_JUMP: begin
                w_redirect     = 1'b1;
                w_redir_target = {ifid_pc_plus4[31:28], jump_index, 2'b00};
            end
            PC_JR: begin
                w_redirect     = 1'b1;
                w_redir_target = jr_addr;
            end
            PC_INTR: begin
                w_redirect     = 1'b1;
                w_redir_target = ILLOP;
            end
            PC_EXC: begin
                w_redirect     = 1'b1;
                w_redir_target = XADR;
            end
            default: ;
        endcase
    end

    // A resolved EX branch overrides both a stall and any ID redirect.
    always_comb begin
        w_pc_next = w_redir_target;
        if (ex_br_taken)
            w_pc_next = ex_br_target;
        else if (stall)
            w_pc_next = r_pc;
    end

    assign w_bubble = ex_br_taken | (w_redirect & ~stall);

    always_ff @(posedge clk) begin
        if (reset)
            r_pc <= RESET_VEC;
        else
            r_pc <= w_pc_next;
    end

    if_id_reg u_if_id_reg (
        .clk        (clk),
        .reset      (reset),
        .i_hold     (stall),
        .i_bubble   (w_bubble),
        .i_instr    (imem_rdata),
        .i_pc_plus4 (w_pc_plus4),
        .o_instr    (ifid_instr),
        .o_pc_plus4 (ifid_pc_plus4),
        .o_valid    (ifid_valid)
    );

    assign imem_addr  = r_pc;
    assign flush_idex = ex_br_taken & ~reset;

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL: reset  input  1  synchronous, active-high; sampled on rising edge of clk.
REQ-003 SHALL: stall  input  1  load-use hold request from hazard unit.
REQ-004 SHALL: pcsrc  input  3  next-PC select from ID-stage control decode.
REQ-005 SHALL: jump_index  input  26  instr[25:0] of the ID-stage instruction.
REQ-006 SHALL: jr_addr  input  32  forwarded rs value for jr/jalr.
REQ-007 SHALL: ex_br_taken  input  1  EX-stage branch resolved taken.
REQ-008 SHALL: ex_br_target  input  32  EX-stage branch target address.
REQ-009 SHALL: imem_addr  output  32  instruction memory address; equals current PC.
REQ-010 SHALL: imem_rdata  input  32  combinational instruction memory read data.
REQ-011 SHALL: ifid_instr  output  32  registered instruction for ID.
REQ-012 SHALL: ifid_pc_plus4  output  32  registered PC+4 for ID; bit 31 is the ID-stage supervisor bit.
REQ-013 SHALL: ifid_valid  output  1  ID slot holds a real fetched instruction.
REQ-014 SHALL: flush_idex  output  1  combinational; asserted when ID/EX must be bubbled.

Function
REQ-015 SHALL: pc_plus4 = {PC[31], PC[30:0]+4}; 31-bit wrap, supervisor bit never altered by increment.
REQ-016 SHALL: pcsrc encoding: 000 seq, 001 branch (resolved in EX, treated as seq here), 010 jump, 011 jr, 100 interrupt, 101 exception, 110/111 seq.
REQ-017 SHALL: jump target = {ifid_pc_plus4[31:28], jump_index, 2'b00}.
REQ-018 SHALL: jr target = jr_addr, all 32 bits, including bit 31 (sole user-mode return path).
REQ-019 SHALL: interrupt target = 0x80000004; exception target = 0x80000008.
REQ-020 SHALL: next-PC priority per edge: reset > ex_br_taken > stall > ID redirect (010/011/100/101) > pc_plus4.
REQ-021 SHALL: ex_br_taken: PC <= ex_br_target; IF/ID <= bubble; flush_idex = 1; stall ignored that cycle.
REQ-022 SHALL: stall without ex_br_taken: PC and IF/ID hold; ID redirect ignored (ID instruction re-decoded next cycle).
REQ-023 SHALL: ID redirect without stall/ex_br_taken: PC <= redirect target; IF/ID <= bubble (wrong-path fetch discarded); flush_idex = 0.
REQ-024 SHALL: otherwise IF/ID <= {imem_rdata, pc_plus4, valid=1}; PC <= pc_plus4.
REQ-025 SHALL: bubble = ifid_instr 0x00000000, ifid_valid 0, ifid_pc_plus4 = pc_plus4 of the discarded fetch (keeps supervisor bit consistent).
REQ-026 SHALL: latency: instruction at PC appears on ifid_instr exactly one edge after PC is presented on imem_addr, absent stall/flush.
REQ-027 SHALL: flush_idex asserted only by ex_br_taken; independent of stall.

Reset
REQ-028 SHALL: on reset: PC = 0x80000000, ifid_instr = 0x00000000, ifid_pc_plus4 = 0x80000000, ifid_valid = 0.
REQ-029 SHALL: reset mid-stall or mid-redirect overrides all; first fetch after release from 0x80000000.
REQ-030 SHALL: flush_idex = 0 while reset is high.

Structure
REQ-031 SHALL: shared cpu_pkg holds PCSrc encodings, RESET_VEC 0x80000000, ILLOP 0x80000004, XADR 0x80000008, NOP 0x00000000.
REQ-032 SHALL: IF/ID register implemented as sub-module if_id_reg (hold/bubble/load controls); next-PC mux and PC register in if_stage.

Verification
REQ-033 SHALL: reset then 3 free cycles, imem_rdata = addr -> imem_addr 0x80000000, 0x80000004, 0x80000008; ifid_instr lags by one, ifid_valid 0 then 1.
REQ-034 SHALL: ifid_pc_plus4 = 0x00400010, pcsrc = 010, jump_index = 0x0000100 -> next PC 0x00000400, IF/ID bubble, flush_idex 0.
REQ-035 SHALL: stall = 1 for 2 cycles with pcsrc = 011 -> PC and IF/ID unchanged; after release jr_addr 0x00400020 taken.
REQ-036 SHALL: stall = 1 and ex_br_taken = 1, ex_br_target 0x00400100 same cycle -> PC 0x00400100, IF/ID bubble, flush_idex 1.
REQ-037 SHALL: pcsrc = 100 then (separate run) 101 -> PC 0x80000004 / 0x80000008; PC 0x7FFFFFFC increments to 0x00000000 (bit 31 kept 0).
REQ-038 SHALL: reset asserted during ID redirect cycle -> PC 0x80000000, ifid_valid 0, flush_idex 0.
